serial_pair_serializer: RTL
===========================

// Module: serial_pair_serializer
//
// PURPOSE
//   Parallel-to-serial transmitter for the serial comparators. Accepts a pair
//   of W-bit operands (a, b) over a valid/ready handshake. Shifts them out one
//   bit per clock on two lanes, MSB first by default.
//   - out_clear: one-cycle pulse that re-initialises a downstream serial
//     comparator before each frame.
//   - out_last: marks the bit on which the comparator result is final.
//
// PARAMETERS
//   W   8   operand width in bits; legal range W >= 2
//
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst_n      in   1   reset; asynchronous, active-low
//   in_valid   in   1   operand pair present
//   in_ready   out  1   block can accept a pair this cycle
//   in_a       in   W   operand a
//   in_b       in   W   operand b
//   out_valid  out  1   out_a/out_b carry a valid bit this cycle
//   out_a      out  1   serial bit of a
//   out_b      out  1   serial bit of b
//   out_clear  out  1   comparator re-init pulse; always precedes the frame's first bit
//   out_last   out  1   final bit of the frame; coincides with out_valid
//
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous):
//     - state = IDLE; shift registers and bit counter = 0.
//     - out_valid, out_a, out_b, out_clear, out_last = 0 immediately.
//     - in_ready = 0 while rst_n is low.
//   - Reset mid-frame: the frame is dropped and no partial bits continue.
//     After release, state is IDLE and in_ready = 1 on the first cycle.
//   - FSM has three states: IDLE, CLEAR, SHIFT.
//   - IDLE:
//     - in_ready = 1, all outputs 0.
//     - On in_valid & in_ready: load in_a/in_b into the shift registers and go to CLEAR.
//   - CLEAR (exactly 1 cycle):
//     - out_clear = 1, out_valid = 0, in_ready = 0.
//     - Next state is SHIFT, with the bit counter = 0.
//   - SHIFT (exactly W cycles):
//     - out_valid = 1.
//     - out_a/out_b = the current head bit of the shift registers.
//     - Shift by one bit each cycle; the counter increments.
//     - out_last = 1 when counter == W-1.
//     - in_ready = 0, except in the last SHIFT cycle, where in_ready = 1.
//   - Leaving the last SHIFT cycle:
//     - If in_valid was high in that cycle, load the new pair and go to CLEAR (back-to-back).
//     - Otherwise go to IDLE.
//   - Latency: pair accepted at edge t.
//     - Cycle t+1: out_clear.
//     - Cycles t+2 .. t+W+1: bits.
//     - Cycle t+W+1: out_last.
//   - Throughput: one pair per W+1 cycles at most.
//   - Data while in_ready = 0 is ignored; the held in_valid is accepted at the next ready cycle.
//   - Outputs are registered or pure state decodes (no input->output combinational path),
//     except in_ready, which depends only on state and counter.
//   - Counter width: $clog2(W). The counter never wraps inside a frame; it resets on CLEAR.
//
// CONFIGURATION
//   SERIAL_PAIR_SER_LSB_FIRST_EN
//     - Undefined (default): MSB first; bit W-1 of each operand is sent first.
//       Matches the MSB-first comparator.
//     - Defined: LSB first; bit 0 is sent first. Matches the LSB-first comparator.
//     - Handshake, out_clear/out_last timing and latency are identical in both modes.
//
// STRUCTURE
//   - Package serial_pkg:
//     - typedef enum logic [1:0] { IDLE, CLEAR, SHIFT } ser_state_t.
//     - Constant CLEAR_CYCLES = 1.
//   - Sub-module serial_piso: W-bit load/shift register with load, shift and head-bit output.
//     The shift direction is selected by the macro. Instantiated twice (lanes a, b).
//   - The top level holds the FSM, counter and handshake.
//
// TESTING (W = 4; each frame's output drives an MSB-first serial comparator, reset by out_clear)
//   1. a=4'b1010, b=4'b1001 accepted at t
//      -> out_clear at t+1.
//      -> out_a = 1,0,1,0 and out_b = 1,0,0,1 over t+2..t+5; out_last at t+5.
//      -> comparator reports a_greater_b at t+5.
//   2. Back-to-back: pairs (3,3) then (2,5), in_valid held high
//      -> in_ready = 1 only in IDLE and the last SHIFT cycle.
//      -> second out_clear the cycle after the first out_last.
//      -> comparator reports a_eq_b, then a_less_b.
//   3. in_valid raised with (9,6) mid-frame
//      -> not accepted until the last SHIFT cycle.
//      -> the current frame's bits are unaffected.
//   4. rst_n pulled low during the 2nd bit of a frame
//      -> out_valid, out_a, out_b, out_last = 0 without waiting for a clock edge.
//      -> after release: in_ready = 1, then a fresh frame transmits correctly.
//   5. SERIAL_PAIR_SER_LSB_FIRST_EN defined; a=4'b1010, b=4'b1001
//      -> out_a = 0,1,0,1 and out_b = 1,0,0,1.
//      -> an LSB-first comparator reports a_greater_b at out_last.
//   6. Random sweep of 1000 pairs with random in_valid gaps
//      -> comparator result at each out_last matches a<b / a==b / a>b.
//      -> no frame is lost or duplicated.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial pair serializer.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;

    localparam int CLEAR_CYCLES = 1;

endpackage

// File: rtl/serial_piso.sv
// W-bit parallel-load shift register exposing the bit to be transmitted next.
// Direction: MSB first, or LSB first when SERIAL_PAIR_SER_LSB_FIRST_EN is defined.
module serial_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         head
);

    logic [W-1:0] sr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
`ifdef SERIAL_PAIR_SER_LSB_FIRST_EN
            sr <= {1'b0, sr[W-1:1]};
`else
            sr <= {sr[W-2:0], 1'b0};
`endif
        end
    end

`ifdef SERIAL_PAIR_SER_LSB_FIRST_EN
    assign head = sr[0];
`else
    assign head = sr[W-1];
`endif

endmodule

// File: rtl/serial_pair_serializer.sv
// Two-lane parallel-to-serial transmitter: clear pulse, then W bits per operand pair.
// Bit order follows SERIAL_PAIR_SER_LSB_FIRST_EN (undefined: MSB first).
module serial_pair_serializer
    import serial_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    output logic         out_a,
    output logic         out_b,
    output logic         out_clear,
    output logic         out_last
);

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    ser_state_t    state;
    ser_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic          last_bit;
    logic          ready_int;
    logic          accept;
    logic          shift_en;
    logic          head_a;
    logic          head_b;

    assign last_bit  = (state == SHIFT) && (cnt == LAST_IDX);
    assign ready_int = (state == IDLE) || last_bit;
    assign accept    = in_valid && ready_int;
    assign shift_en  = (state == SHIFT);

    // Ready is forced low during reset; kept out of the flop D-paths on purpose.
    assign in_ready  = rst_n && ready_int;

    always_comb begin
        // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = CLEAR;
            CLEAR:   state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = accept ? CLEAR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (shift_en && !last_bit) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // A load on the last SHIFT cycle takes priority over the shift (back-to-back frames).
    serial_piso #(.W(W)) u_lane_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (shift_en),
        .din   (in_a),
        .head  (head_a)
    );

    serial_piso #(.W(W)) u_lane_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (shift_en),
        .din   (in_b),
        .head  (head_b)
    );

    assign out_valid = shift_en;
    assign out_clear = (state == CLEAR);
    assign out_last  = last_bit;
    assign out_a     = shift_en && head_a;
    assign out_b     = shift_en && head_b;

endmodule
